// File: rtl/uart_cmd_parser.sv
// Frame parser for the gripper UART path: SYNC, CMD, LEN, payload, CHK -> validated command.
// Latency: cmd_valid/frame_error one cycle after the deciding byte; no backpressure, every rx_valid byte is consumed.
module uart_cmd_parser #(
    parameter int          MAX_PAYLOAD    = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic                     cmd_valid,
    output logic [7:0]               cmd_code,
    output logic [3:0]               cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     frame_error,
    output logic [1:0]               error_code,
    output logic [7:0]               error_count
);
    localparam int              TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TLIM  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAXP8 = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {HUNT, GET_CMD, GET_LEN, GET_PAY, GET_CHK} state_t;

    state_t                     state;
    logic [TW-1:0]              idle_cnt;
    logic [7:0]                 sum;
    logic [3:0]                 idx;
    logic [7:0]                 sh_code;
    logic [3:0]                 sh_len;
    logic [8*MAX_PAYLOAD-1:0]   sh_pay;

    logic                       timeout_hit;
    logic                       err_hit;
    logic [1:0]                 err_kind;

    // A byte arriving on the limit cycle wins over the timeout.
    always_comb begin
        timeout_hit = (state != HUNT) && !rx_valid && (idle_cnt == TLIM);
        err_hit     = 1'b0;
        err_kind    = 2'b00;
        if (timeout_hit) begin
            err_hit  = 1'b1;
            err_kind = 2'b11;
        end else if (rx_valid && state == GET_LEN && rx_byte > MAXP8) begin
            err_hit  = 1'b1;
            err_kind = 2'b01;
        end else if (rx_valid && state == GET_CHK && rx_byte != sum) begin
            err_hit  = 1'b1;
            err_kind = 2'b10;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= HUNT;
            idle_cnt    <= '0;
            sum         <= '0;
            idx         <= '0;
            sh_code     <= '0;
            sh_len      <= '0;
            sh_pay      <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            frame_error <= 1'b0;
            error_code  <= 2'b00;
            error_count <= '0;
        end else begin
            cmd_valid   <= 1'b0;
            frame_error <= 1'b0;

            if (state == HUNT || rx_valid || timeout_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (timeout_hit)
                state <= HUNT;

            if (err_hit) begin
                frame_error <= 1'b1;
                error_code  <= err_kind;
                if (error_count != 8'hFF)
                    error_count <= error_count + 1'b1;
            end

            if (rx_valid) begin
                case (state)
                    HUNT: begin
                        if (rx_byte == SYNC_BYTE)
                            state <= GET_CMD;
                    end
                    GET_CMD: begin
                        sh_code <= rx_byte;
                        sum     <= rx_byte;
                        state   <= GET_LEN;
                    end
                    GET_LEN: begin
                        if (rx_byte > MAXP8) begin
                            state <= HUNT;
                        end else begin
                            // Clearing here keeps bytes at and above cmd_len reading zero.
                            sh_len <= rx_byte[3:0];
                            sh_pay <= '0;
                            sum    <= sum + rx_byte;
                            idx    <= '0;
                            state  <= (rx_byte == 8'd0) ? GET_CHK : GET_PAY;
                        end
                    end
                    GET_PAY: begin
                        sh_pay[idx*8 +: 8] <= rx_byte;
                        sum                <= sum + rx_byte;
                        idx                <= idx + 1'b1;
                        if (idx == sh_len - 4'd1)
                            state <= GET_CHK;
                    end
                    GET_CHK: begin
                        if (rx_byte == sum) begin
                            cmd_code    <= sh_code;
                            cmd_len     <= sh_len;
                            cmd_payload <= sh_pay;
                            cmd_valid   <= 1'b1;
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a 50-cycle inter-byte timeout.
module tb_uart_cmd_parser;
    localparam int MP = 4;

    logic          CLK;
    logic          RESET_N;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          cmd_valid;
    logic [7:0]    cmd_code;
    logic [3:0]    cmd_len;
    logic [8*MP-1:0] cmd_payload;
    logic          frame_error;
    logic [1:0]    error_code;
    logic [7:0]    error_count;

    int tests = 0;
    int fails = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int first_fe;
    int fe_seen;

    uart_cmd_parser #(.MAX_PAYLOAD(MP), .SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(50)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len),
        .cmd_payload(cmd_payload), .frame_error(frame_error),
        .error_code(error_code), .error_count(error_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (cmd_valid) cv_cnt++;
        if (frame_error) fe_cnt++;
        if (cmd_valid && frame_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte; returns 1 time unit after the edge that sampled it.
    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RESET_N  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        idle(3);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code", 32'(cmd_code), 32'd0);
        check("rst_cmd_len", 32'(cmd_len), 32'd0);
        check("rst_payload", cmd_payload, 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_error_code", 32'(error_code), 32'd0);
        check("rst_error_count", 32'(error_count), 32'd0);
        RESET_N = 1'b1;
        idle(2);

        // Good frame, back-to-back bytes.
        send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20);
        check("good1_no_valid_early", 32'(cmd_valid), 32'd0);
        send(8'h33);
        check("good1_valid", 32'(cmd_valid), 32'd1);
        check("good1_code", 32'(cmd_code), 32'h01);
        check("good1_len", 32'(cmd_len), 32'd2);
        check("good1_payload", cmd_payload, 32'h0000_2010);
        check("good1_err_count", 32'(error_count), 32'd0);
        idle(1);
        check("good1_pulse_one_cycle", 32'(cmd_valid), 32'd0);

        // Checksum failure: expected 85, sent 00.
        send(8'hAA); send(8'h05); send(8'h01); send(8'h7F); send(8'h00);
        check("cksum_frame_error", 32'(frame_error), 32'd1);
        check("cksum_no_valid", 32'(cmd_valid), 32'd0);
        check("cksum_code", 32'(error_code), 32'b10);
        check("cksum_count", 32'(error_count), 32'd1);
        check("cksum_cmd_code_kept", 32'(cmd_code), 32'h01);
        check("cksum_payload_kept", cmd_payload, 32'h0000_2010);

        // Length failure, then junk and a zero-length frame.
        send(8'hAA); send(8'h03); send(8'h05);
        check("len_frame_error", 32'(frame_error), 32'd1);
        check("len_code", 32'(error_code), 32'b01);
        check("len_count", 32'(error_count), 32'd2);
        send(8'h11); send(8'hAA); send(8'h02); send(8'h00); send(8'h02);
        check("len0_valid", 32'(cmd_valid), 32'd1);
        check("len0_code", 32'(cmd_code), 32'h02);
        check("len0_len", 32'(cmd_len), 32'd0);
        check("len0_payload", cmd_payload, 32'd0);
        check("len0_count", 32'(error_count), 32'd2);

        // Timeout: frame_error on the 50th edge after the last byte was sampled.
        send(8'hAA); send(8'h01);
        first_fe = 0;
        fe_seen  = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge CLK);
            #1;
            if (frame_error) begin
                fe_seen++;
                if (first_fe == 0) first_fe = i;
            end
        end
        check("tmo_first_edge", 32'(first_fe), 32'd50);
        check("tmo_pulses", 32'(fe_seen), 32'd1);
        check("tmo_code", 32'(error_code), 32'b11);
        check("tmo_count", 32'(error_count), 32'd3);
        check("tmo_cmd_code_kept", 32'(cmd_code), 32'h02);
        send(8'hAA); send(8'h04); send(8'h01); send(8'hAA); send(8'hAF);
        check("tmo_next_valid", 32'(cmd_valid), 32'd1);
        check("tmo_next_code", 32'(cmd_code), 32'h04);
        check("tmo_next_payload", cmd_payload, 32'h0000_00AA);

        // Byte lands on the limit cycle: no error.
        send(8'hAA); send(8'h07); send(8'h01);
        idle(49);
        check("bnd_no_error_before", 32'(frame_error), 32'd0);
        send(8'h05);
        check("bnd_no_error_at_limit", 32'(frame_error), 32'd0);
        send(8'h0D);
        check("bnd_valid", 32'(cmd_valid), 32'd1);
        check("bnd_code", 32'(cmd_code), 32'h07);
        check("bnd_payload", cmd_payload, 32'h0000_0005);
        check("bnd_count", 32'(error_count), 32'd3);

        // Reset mid-payload.
        send(8'hAA); send(8'h09); send(8'h03); send(8'h01); send(8'h02);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_code", 32'(cmd_code), 32'd0);
        check("mid_rst_len", 32'(cmd_len), 32'd0);
        check("mid_rst_payload", cmd_payload, 32'd0);
        check("mid_rst_err_code", 32'(error_code), 32'd0);
        check("mid_rst_err_count", 32'(error_count), 32'd0);
        idle(2);
        RESET_N = 1'b1;
        idle(1);
        send(8'hAA); send(8'h0B); send(8'h00); send(8'h0B);
        check("post_rst_valid", 32'(cmd_valid), 32'd1);
        check("post_rst_code", 32'(cmd_code), 32'h0B);

        // 300 bad-length frames saturate the error counter.
        for (int k = 0; k < 300; k++) begin
            send(8'hAA); send(8'h00); send(8'h09);
        end
        idle(1);
        check("sat_count", 32'(error_count), 32'd255);
        check("sat_code", 32'(error_code), 32'b01);
        check("sat_cmd_code_kept", 32'(cmd_code), 32'h0B);

        idle(2);
        check("total_cmd_valid", 32'(cv_cnt), 32'd5);
        check("total_frame_error", 32'(fe_cnt), 32'd303);
        check("never_both", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
